// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and sizing helper for the debounce_edge input conditioner.
package debounce_pkg;
   localparam int SYNC_STAGES_DEF  = 2;
   localparam int DEBOUNCE_CNT_DEF = 4;
   localparam int CNT_W_DEF        = 16;
   // smallest counter width that can hold DEBOUNCE_CNT-1
   function automatic int min_cnt_w(input int debounce_cnt);
      return (debounce_cnt <= 2) ? 1 : $clog2(debounce_cnt);
   endfunction
endpackage

// File: rtl/sync_chain.sv
// sync_chain: multi-flop synchronizer bringing an asynchronous level into the clk domain.
module sync_chain #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic s
);
   logic [STAGES-1:0] sync_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync_q <= '0;
      else     sync_q <= {sync_q[STAGES-2:0], d};
   end
   assign s = sync_q[STAGES-1];
endmodule

// File: rtl/debounce_edge.sv
// debounce_edge: synchronize, debounce and edge-detect a raw level.
// FALL_DET_EN adds the fall pulse output and its register.
module debounce_edge
   import debounce_pkg::*;
#(
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF,
   parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF,
   parameter int CNT_W        = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q,
   output logic rise,
`ifdef FALL_DET_EN
   output logic fall,
`endif
   output logic busy
);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CNT - 1);
   logic             s, mismatch, accept;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d, rise_q, rise_d;
   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(clk),
      .rst(rst),
      .d  (d),
      .s  (s)
   );
   // any cycle where s agrees with q restarts the window from zero
   assign mismatch = s ^ level_q;
   assign accept   = mismatch && (cnt_q == LAST);
   always_comb begin
      cnt_d   = (mismatch && !accept) ? cnt_q + CNT_W'(1) : '0;
      level_d = accept ? s : level_q;
      rise_d  = accept & s;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end
`ifdef FALL_DET_EN
   logic fall_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) fall_q <= 1'b0;
      else     fall_q <= accept & ~s;
   end
   assign fall = fall_q;
`endif
   assign q    = level_q;
   assign rise = rise_q;
   assign busy = cnt_q != '0;
endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge: scoreboard bench with a windowed reference model of the debouncer.
module tb_debounce_edge;
   import debounce_pkg::*;
   localparam int SS = 2;
   localparam int DC = 4;
   logic clk = 0, rst = 1, d = 0;
   logic q, rise, busy;
`ifdef FALL_DET_EN
   logic fall;
`endif
   always #5 clk = ~clk;
   debounce_edge #(.SYNC_STAGES(SS), .DEBOUNCE_CNT(DC), .CNT_W(CNT_W_DEF)) dut (
      .clk (clk),
      .rst (rst),
      .d   (d),
      .q   (q),
      .rise(rise),
`ifdef FALL_DET_EN
      .fall(fall),
`endif
      .busy(busy)
   );
   typedef struct packed {logic q, rise, fall, busy;} exp_t;
   exp_t sb[$];
   bit   dline[$];
   bit   shist[$];
   bit   mq;
   int   n_vec = 0, n_bad = 0, n_rise = 0, n_fall = 0;
   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endfunction
   function automatic void model_reset();
      dline.delete();
      for (int i = 0; i < SS; i++) dline.push_back(1'b0);
      shist.delete();
      mq = 1'b0;
   endfunction
   // model: a change is accepted once the last DC synchronized samples all differ from q
   task automatic step(input bit dv);
      exp_t e;
      bit   s, acc;
      @(negedge clk);
      d = dv;
      @(posedge clk);
      e = '0;
      if (rst) model_reset();
      else begin
         s = dline.pop_front();
         dline.push_back(dv);
         shist.push_back(s);
         if (shist.size() > DC) void'(shist.pop_front());
         acc = (shist.size() == DC);
         foreach (shist[i]) if (shist[i] == mq) acc = 0;
         e.busy = !acc && (s != mq);
         if (acc) begin
            mq = s;
            shist.delete();
         end
         e.q    = mq;
         e.rise = acc && s;
         e.fall = acc && !s;
      end
      sb.push_back(e);
   endtask
   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("q", q, e.q);
            chk("rise", rise, e.rise);
            chk("busy", busy, e.busy);
`ifdef FALL_DET_EN
            chk("fall", fall, e.fall);
            if (fall) n_fall++;
`endif
            if (rise) n_rise++;
         end
         chk("cnt_bound", dut.cnt_q <= 16'(DC - 1), 1);
      end
   end
   // called right after a step returns, so the scoreboard is empty
   task automatic async_reset_release();
      #2 rst = 1;
      #1;
      chk("rst_q", q, 0);
      chk("rst_rise", rise, 0);
      chk("rst_busy", busy, 0);
`ifdef FALL_DET_EN
      chk("rst_fall", fall, 0);
`endif
      #1 rst = 0;
      model_reset();
   endtask
   initial begin : stim
      int r0, f0, len;
      bit v;
      model_reset();
      repeat (3) step(0);
      @(negedge clk) rst = 0;
      repeat (20) step(0);
      r0 = n_rise;
      repeat (10) step(1);
      chk("hold_rise_cnt", n_rise - r0, 1);
      f0 = n_fall;
      r0 = n_rise;
      repeat (10) step(0);
      chk("drop_rise_cnt", n_rise - r0, 0);
`ifdef FALL_DET_EN
      chk("drop_fall_cnt", n_fall - f0, 1);
`endif
      r0 = n_rise;
      repeat (3) step(1);
      repeat (10) step(0);
      chk("pulse3_rise_cnt", n_rise - r0, 0);
      r0 = n_rise;
      repeat (4) step(1);
      repeat (10) step(0);
      chk("pulse4_rise_cnt", n_rise - r0, 1);
      repeat (4) step(1);
      async_reset_release();
      r0 = n_rise;
      repeat (8) step(1);
      chk("post_rst_q", q, 1);
      chk("post_rst_rise_cnt", n_rise - r0, 1);
      r0 = n_rise;
      f0 = n_fall;
      for (int i = 0; i < 50; i++) step(1'(i % 2));
      step(0);
      chk("toggle_rise_cnt", n_rise - r0, 0);
      chk("toggle_fall_cnt", n_fall - f0, 0);
      repeat (12) step(1);
      for (int i = 0; i < 120; i++) begin
         v   = 1'($urandom);
         len = $urandom_range(1, 7);
         for (int j = 0; j < len; j++) step(v);
      end
      repeat (3) step(d);
      @(posedge clk);
      #2;
      chk("sb_drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
